// File: rtl/mm_job_sched_pkg.sv
// mm_job_sched_pkg: scheduler states and job framing constants.
package mm_job_sched_pkg;
  typedef enum logic [1:0] {IDLE, RST, LOAD, DRAIN} state_t;
  localparam int B_WORDS = 16;
  localparam int JOB_IN_WORDS = 2 * B_WORDS;
  localparam int JOB_OUT_WORDS = 16;
endpackage

// File: rtl/mm_job_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer remembers the last winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         axis_clk,
  input  logic         axis_rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         upd,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, win;
  // Scan farthest-first so the nearest requester after ptr overwrites last.
  always_comb begin
    win = ptr;
    for (int k = N; k >= 1; k--)
      for (int i = 0; i < N; i++)
        if (req[i] && i == (int'(ptr) + k) % N) win = PW'(i);
    gnt = (en && |req) ? N'(1) << win : '0;
  end
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) ptr <= PW'(N - 1);
    else if (upd) ptr <= win;
endmodule

// File: rtl/mm_job_sched.sv
// mm_job_sched: round-robin job scheduler sharing one 4x4 matmul engine between requesters.
// Define MM_JOB_SCHED_TIMEOUT_EN to add a drain watchdog that aborts a stalled job.
module mm_job_sched
  import mm_job_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW = 32,
  parameter int ENG_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic [N_REQ-1:0]    req_tvalid,
  input  logic [N_REQ*DW-1:0] req_tdata,
  input  logic [N_REQ-1:0]    req_tlast,
  output logic [N_REQ-1:0]    req_tready,
  output logic [N_REQ-1:0]    rsp_tvalid,
  output logic [DW-1:0]       rsp_tdata,
  output logic              rsp_tlast,
  input  logic [N_REQ-1:0]    rsp_tready,
  output logic              eng_rst_n,
  output logic              eng_ss_tvalid,
  output logic [DW-1:0]       eng_ss_tdata,
  output logic              eng_ss_tlast,
  input  logic              eng_ss_tready,
  input  logic              eng_sm_tvalid,
  input  logic [DW-1:0]       eng_sm_tdata,
  output logic              eng_sm_tready,
  output logic              busy,
  output logic [N_REQ-1:0]    grant,
  output logic [15:0]         jobs_done,
  output logic              err_tlast,
  output logic              err_timeout
);
  localparam int RCW = $clog2(ENG_RST_CYCLES + 1);
  state_t state;
  logic [N_REQ-1:0] arb_gnt;
  logic [RCW-1:0] rst_cnt;
  logic [5:0] in_cnt;
  logic [3:0] out_cnt;
  logic in_hs, out_hs, g_tlast, wd_fire;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .req       (req_tvalid),
    .en        (state == IDLE),
    .upd       (state == IDLE && |req_tvalid),
    .gnt       (arb_gnt)
  );
  always_comb begin
    eng_ss_tdata = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) eng_ss_tdata = req_tdata[i*DW +: DW];
  end
  assign busy          = state != IDLE;
  assign eng_ss_tvalid = state == LOAD && |(req_tvalid & grant);
  assign eng_ss_tlast  = state == LOAD && in_cnt == 6'(JOB_IN_WORDS - 1);
  assign req_tready    = (state == LOAD && eng_ss_tready) ? grant : '0;
  assign in_hs         = eng_ss_tvalid && eng_ss_tready;
  assign g_tlast       = |(req_tlast & grant);
  assign rsp_tvalid    = (state == DRAIN && eng_sm_tvalid) ? grant : '0;
  assign rsp_tdata     = eng_sm_tdata;
  assign rsp_tlast     = state == DRAIN && eng_sm_tvalid && out_cnt == 4'(JOB_OUT_WORDS - 1);
  assign eng_sm_tready = state == DRAIN && |(rsp_tready & grant);
  assign out_hs        = eng_sm_tvalid && eng_sm_tready;
`ifdef MM_JOB_SCHED_TIMEOUT_EN
  logic [15:0] wd;
  assign wd_fire = state == DRAIN && !out_hs && wd == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      wd          <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd <= (state == DRAIN && !out_hs && !wd_fire) ? wd + 1'b1 : '0;
      if (wd_fire) err_timeout <= 1'b1;
    end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif
  // Engine stays in reset from power-up until the first job's RST phase ends.
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rst_cnt   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      jobs_done <= '0;
      err_tlast <= 1'b0;
      eng_rst_n <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (|req_tvalid) begin
            grant     <= arb_gnt;
            eng_rst_n <= 1'b0;
            rst_cnt   <= RCW'(ENG_RST_CYCLES - 1);
            state     <= RST;
          end
        RST:
          if (rst_cnt == '0) begin
            eng_rst_n <= 1'b1;
            state     <= LOAD;
          end else rst_cnt <= rst_cnt - 1'b1;
        LOAD:
          if (in_hs) begin
            in_cnt <= in_cnt + 1'b1;
            if (g_tlast != (in_cnt == 6'(JOB_IN_WORDS - 1))) err_tlast <= 1'b1;
            if (in_cnt == 6'(JOB_IN_WORDS - 1)) begin
              in_cnt <= '0;
              state  <= DRAIN;
            end
          end
        DRAIN:
          if (wd_fire) begin
            out_cnt <= '0;
            grant   <= '0;
            state   <= IDLE;
          end else if (out_hs) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == 4'(JOB_OUT_WORDS - 1)) begin
              out_cnt   <= '0;
              jobs_done <= jobs_done + 1'b1;
              grant     <= '0;
              state     <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mm_job_sched.sv
// tb_mm_job_sched: scoreboard bench with a behavioural 4x4 engine behind mm_job_sched.
module tb_mm_job_sched;
  localparam int N = 2, DW = 32;
  typedef logic [DW-1:0] job_t [32];
  logic axis_clk = 1'b0, axis_rst_n = 1'b0;
  logic [N-1:0] req_tvalid = '0, req_tlast = '0, rsp_tready = '0;
  logic [N-1:0] req_tready, rsp_tvalid, grant;
  logic [N*DW-1:0] req_tdata = '0;
  logic [DW-1:0] rsp_tdata, eng_ss_tdata, eng_sm_tdata;
  logic rsp_tlast, eng_rst_n, eng_ss_tvalid, eng_ss_tlast, eng_ss_tready;
  logic eng_sm_tvalid, eng_sm_tready, busy, err_tlast, err_timeout;
  logic [15:0] jobs_done;
  mm_job_sched #(.N_REQ(N), .DW(DW)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .req_tvalid(req_tvalid), .req_tdata(req_tdata), .req_tlast(req_tlast), .req_tready(req_tready),
    .rsp_tvalid(rsp_tvalid), .rsp_tdata(rsp_tdata), .rsp_tlast(rsp_tlast), .rsp_tready(rsp_tready),
    .eng_rst_n(eng_rst_n), .eng_ss_tvalid(eng_ss_tvalid), .eng_ss_tdata(eng_ss_tdata),
    .eng_ss_tlast(eng_ss_tlast), .eng_ss_tready(eng_ss_tready), .eng_sm_tvalid(eng_sm_tvalid),
    .eng_sm_tdata(eng_sm_tdata), .eng_sm_tready(eng_sm_tready), .busy(busy), .grant(grant),
    .jobs_done(jobs_done), .err_tlast(err_tlast), .err_timeout(err_timeout)
  );
  always #5 axis_clk = ~axis_clk;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Result word idx of C = A*B, row-major; B is words 0..15, A is words 16..31.
  function automatic logic [DW-1:0] mm(input job_t w, input int idx);
    logic [DW-1:0] s = '0;
    int r = (idx % 16) / 4, c = idx % 4;
    for (int k = 0; k < 4; k++) s += w[16 + r*4 + k] * w[k*4 + c];
    return s;
  endfunction
  function automatic void mk_job(output job_t w, input int kind);
    for (int i = 0; i < 32; i++)
      w[i] = kind == 0 ? DW'((i % 16) / 4 == i % 4) :
             kind == 1 ? DW'($urandom_range(0, 255)) :
             (i < 16 ? DW'(i + 1) : DW'(2));
  endfunction
  job_t e_in;
  int e_ic = 0, e_oc = 0, cyc = 0;
  logic ss_en = 1'b1, kill_sm = 1'b0, bp = 1'b0;
  assign eng_ss_tready = ss_en && e_ic < 32;
  assign eng_sm_tvalid = e_ic == 32 && e_oc < 16 && !kill_sm;
  assign eng_sm_tdata  = mm(e_in, e_oc);
  // Engine counters are sticky: only an eng_rst_n pulse lets it take another job.
  always @(posedge axis_clk)
    if (!eng_rst_n) begin
      e_ic <= 0;
      e_oc <= 0;
    end else begin
      if (eng_ss_tvalid && eng_ss_tready) begin
        e_in[e_ic] <= eng_ss_tdata;
        e_ic <= e_ic + 1;
        chk("ss_tlast", eng_ss_tlast, e_ic == 31);
      end
      if (eng_sm_tvalid && eng_sm_tready) e_oc <= e_oc + 1;
    end
  always @(negedge axis_clk) begin
    cyc++;
    ss_en = !bp || (cyc % 3 != 0);
    rsp_tready = (!bp || cyc[0]) ? '1 : '0;
  end
  logic [DW-1:0] exp_q[N][$];
  int rcnt[N];
  int glog[$];
  int rlow = 0;
  logic [N-1:0] prev_g = '0;
  always @(negedge axis_clk) begin
    #2;
    for (int r = 0; r < N; r++)
      if (rsp_tvalid[r] && rsp_tready[r]) begin
        if (exp_q[r].size() == 0) chk($sformatf("rsp%0d_unexpected", r), rsp_tvalid[r], 0);
        else begin
          chk($sformatf("rsp%0d_data", r), rsp_tdata, exp_q[r].pop_front());
          chk($sformatf("rsp%0d_tlast", r), rsp_tlast, rcnt[r] % 16 == 15);
          rcnt[r]++;
        end
      end
    if (grant != 0 && prev_g == 0) glog.push_back(int'(grant));
    prev_g = grant;
    if (!axis_rst_n) rlow = 0;
    else if (busy && !eng_rst_n) rlow++;
    else if (rlow != 0) begin
      chk("eng_rst_len", rlow, 2);
      rlow = 0;
    end
  end
  task automatic flush();
    for (int r = 0; r < N; r++) begin
      exp_q[r].delete();
      rcnt[r] = 0;
    end
  endtask
  task automatic send_job(input int r, input job_t w, input int bad, input int stop);
    int n;
    for (int i = 0; i < 16; i++) exp_q[r].push_back(mm(w, i));
    for (int i = 0; i < stop; i++) begin
      @(negedge axis_clk);
      req_tvalid[r] = 1'b1;
      req_tdata[r*DW +: DW] = w[i];
      req_tlast[r] = (i == 31) || (i == bad);
      #1;
      n = 0;
      while (!req_tready[r] && n < 5000) begin
        @(negedge axis_clk);
        #1;
        n++;
      end
      if (n == 5000) begin
        chk($sformatf("req%0d_stall", r), req_tready[r], 1);
        break;
      end
    end
    @(negedge axis_clk);
    req_tvalid[r] = 1'b0;
    req_tlast[r] = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 3000) begin
      @(negedge axis_clk);
      n++;
    end
    chk(tag, int'(busy) + exp_q[0].size() + exp_q[1].size(), 0);
  endtask
  task automatic do_reset();
    @(negedge axis_clk);
    axis_rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_req_tready", req_tready, 0);
    chk("rst_rsp_tvalid", rsp_tvalid, 0);
    chk("rst_rsp_tlast", rsp_tlast, 0);
    chk("rst_ss_tvalid", eng_ss_tvalid, 0);
    chk("rst_sm_tready", eng_sm_tready, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_err_tlast", err_tlast, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    flush();
    repeat (3) @(negedge axis_clk);
    axis_rst_n = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    job_t j;
    do_reset();
    mk_job(j, 0);
    send_job(0, j, -1, 32);
    wait_idle("ident_idle");
    chk("ident_jobs_done", jobs_done, 1);
    chk("ident_err_tlast", err_tlast, 0);
    do_reset();
    glog.delete();
    fork
      begin
        job_t a;
        for (int k = 0; k < 3; k++) begin
          mk_job(a, 1);
          send_job(0, a, -1, 32);
        end
      end
      begin
        job_t b;
        for (int k = 0; k < 3; k++) begin
          mk_job(b, 1);
          send_job(1, b, -1, 32);
        end
      end
    join
    wait_idle("rr_idle");
    chk("rr_jobs", glog.size(), 6);
    for (int i = 0; i < glog.size() && i < 6; i++) chk($sformatf("rr_grant%0d", i), glog[i], i % 2 ? 2 : 1);
    chk("rr_jobs_done", jobs_done, 6);
    bp = 1'b1;
    mk_job(j, 2);
    send_job(1, j, -1, 32);
    wait_idle("bp_idle");
    bp = 1'b0;
    chk("bp_jobs_done", jobs_done, 7);
    mk_job(j, 1);
    send_job(1, j, 9, 32);
    wait_idle("tlast_idle");
    chk("tlast_err", err_tlast, 1);
    mk_job(j, 1);
    send_job(0, j, -1, 32);
    wait_idle("tlast_next_idle");
    chk("tlast_sticky", err_tlast, 1);
    chk("tlast_jobs_done", jobs_done, 9);
    mk_job(j, 0);
    send_job(0, j, -1, 20);
    repeat (2) @(negedge axis_clk);
    do_reset();
    send_job(0, j, -1, 32);
    wait_idle("midrst_idle");
    chk("midrst_jobs_done", jobs_done, 1);
`ifdef MM_JOB_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      kill_sm = 1'b1;
      send_job(1, j, -1, 32);
      while (busy && n < 2000) begin
        @(negedge axis_clk);
        n++;
      end
      chk("to_err", err_timeout, 1);
      chk("to_busy", busy, 0);
      flush();
      kill_sm = 1'b0;
      send_job(1, j, -1, 32);
      wait_idle("to_next_idle");
      chk("to_jobs_done", jobs_done, 2);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
